// File: rtl/sc_march_pkg.sv
// sc_march_pkg: shared definitions for the alien march scheduler.
//   march_state_e : sweep pattern states (RIGHT -> DOWN_R -> LEFT -> DOWN_L)
//   DIR_*         : encodings driven on the dir output
//   state_dir     : direction code for the pass owned by a state
//   next_sweep    : successor state in the sweep pattern
package sc_march_pkg;

  typedef enum logic [1:0] {
    ST_RIGHT  = 2'd0,
    ST_DOWN_R = 2'd1,
    ST_LEFT   = 2'd2,
    ST_DOWN_L = 2'd3
  } march_state_e;

  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_DOWN  = 2'b00;

  function automatic logic [1:0] state_dir(input march_state_e s);
    case (s)
      ST_RIGHT: state_dir = DIR_RIGHT;
      ST_LEFT:  state_dir = DIR_LEFT;
      default:  state_dir = DIR_DOWN;
    endcase
  endfunction

  function automatic march_state_e next_sweep(input march_state_e s);
    case (s)
      ST_RIGHT:  next_sweep = ST_DOWN_R;
      ST_DOWN_R: next_sweep = ST_LEFT;
      ST_LEFT:   next_sweep = ST_DOWN_L;
      default:   next_sweep = ST_RIGHT;
    endcase
  endfunction

endpackage

// File: rtl/sc_march_prescaler.sv
// sc_march_prescaler: march tick generator.
//   Down-counter that reloads period-1 at zero and raises tick_o for that
//   cycle, so ticks are `period` cycles apart. Counting only while run_i.
//   Each kill shortens the period by SPEEDUP, saturating at MIN_PERIOD; the
//   new period is picked up at the next reload.
// Ports:
//   clk_i     system clock
//   rst_ni    async reset, active low
//   run_i     1 = count, 0 = hold
//   clear_i   sync restart to wave-start values (wins over kill and tick)
//   kill_i    1-cycle speed-up request
//   tick_o    combinational tick (counter at zero while running)
//   period_o  current tick period
module sc_march_prescaler #(
  parameter int             PW          = 20,
  parameter logic [PW-1:0]  BASE_PERIOD = PW'(500000),
  parameter logic [PW-1:0]  SPEEDUP     = PW'(20000),
  parameter logic [PW-1:0]  MIN_PERIOD  = PW'(100000)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          run_i,
  input  logic          clear_i,
  input  logic          kill_i,
  output logic          tick_o,
  output logic [PW-1:0] period_o
);

  logic [PW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] period_q, period_d;
  logic [PW-1:0] period_fast;

  // Saturating decrement; the first term guards against wrap below zero.
  always_comb begin
    if ((period_q >= SPEEDUP) && ((period_q - SPEEDUP) > MIN_PERIOD))
      period_fast = period_q - SPEEDUP;
    else
      period_fast = MIN_PERIOD;
  end

  always_comb begin
    tick_o   = 1'b0;
    cnt_d    = cnt_q;
    period_d = period_q;
    if (clear_i) begin
      cnt_d    = BASE_PERIOD - PW'(1);
      period_d = BASE_PERIOD;
    end else begin
      if (run_i) begin
        if (cnt_q == '0) begin
          tick_o = 1'b1;
          // period_q is still the old value here, so a same-cycle kill
          // only affects the following reload.
          cnt_d  = period_q - PW'(1);
        end else begin
          cnt_d  = cnt_q - PW'(1);
        end
      end
      if (kill_i)
        period_d = period_fast;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= BASE_PERIOD - PW'(1);
      period_q <= BASE_PERIOD;
    end else begin
      cnt_q    <= cnt_d;
      period_q <= period_d;
    end
  end

  assign period_o = period_q;

endmodule

// File: rtl/sc_march_scheduler.sv
// sc_march_scheduler: alien-formation march sequencer.
//   Each prescaler tick strobes one alive row, round-robin in ascending row
//   order. A pass ends when no alive row remains at/above the row pointer;
//   the same tick then starts the next pass at the lowest alive row.
//   Completed passes drive the sweep FSM:
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_RIGHT  | STEPS passes moving right (dir 01)
//   ST_DOWN_R | one pass moving down after the right sweep (dir 00)
//   ST_LEFT   | STEPS passes moving left (dir 10)
//   ST_DOWN_L | one pass moving down after the left sweep (dir 00)
//
// Ports:
//   SC_MARCH_CLOCK_50       system clock
//   SC_MARCH_RESET_InLow    async reset, active low
//   SC_MARCH_run_InLow      0 = march, 1 = freeze
//   SC_MARCH_clear_InLow    sync new-wave restart, active low
//   SC_MARCH_kill_InLow     alien destroyed, active-low 1-cycle pulse
//   SC_MARCH_rowAlive_In    per-row live flags
//   SC_MARCH_rowStep_Out    one-hot row step strobe
//   SC_MARCH_dir_Out        01 right, 10 left, 00 down
//   SC_MARCH_sweepDone_Out  pulse with the last strobe of a down pass
//   SC_MARCH_period_Out     current tick period
module sc_march_scheduler
  import sc_march_pkg::*;
#(
  parameter int             ROWS        = 5,
  parameter int             PW          = 20,
  parameter logic [PW-1:0]  BASE_PERIOD = PW'(500000),
  parameter logic [PW-1:0]  SPEEDUP     = PW'(20000),
  parameter logic [PW-1:0]  MIN_PERIOD  = PW'(100000),
  parameter int             STEPS       = 5
) (
  input  logic            SC_MARCH_CLOCK_50,
  input  logic            SC_MARCH_RESET_InLow,
  input  logic            SC_MARCH_run_InLow,
  input  logic            SC_MARCH_clear_InLow,
  input  logic            SC_MARCH_kill_InLow,
  input  logic [ROWS-1:0] SC_MARCH_rowAlive_In,
  output logic [ROWS-1:0] SC_MARCH_rowStep_Out,
  output logic [1:0]      SC_MARCH_dir_Out,
  output logic            SC_MARCH_sweepDone_Out,
  output logic [PW-1:0]   SC_MARCH_period_Out
);

  // Pointer must be able to hold ROWS (one past the top row).
  localparam int PTRW = $clog2(ROWS + 1);
  localparam int SW   = $clog2(STEPS + 1);

  march_state_e    state_q, state_d, pass_st;
  logic [SW-1:0]   step_q, step_d, step_inc;
  logic [PTRW-1:0] ptr_q, ptr_d, sel;
  logic [ROWS-1:0] row_step_q, row_step_d;
  logic [1:0]      dir_q, dir_d;
  logic            sweep_q, sweep_d;
  logic [ROWS-1:0] ahead;
  logic            tick;
  logic            clear;

  assign clear = ~SC_MARCH_clear_InLow;

  sc_march_prescaler #(
    .PW          (PW),
    .BASE_PERIOD (BASE_PERIOD),
    .SPEEDUP     (SPEEDUP),
    .MIN_PERIOD  (MIN_PERIOD)
  ) u_prescaler (
    .clk_i    (SC_MARCH_CLOCK_50),
    .rst_ni   (SC_MARCH_RESET_InLow),
    .run_i    (~SC_MARCH_run_InLow),
    .clear_i  (clear),
    .kill_i   (~SC_MARCH_kill_InLow),
    .tick_o   (tick),
    .period_o (SC_MARCH_period_Out)
  );

  function automatic logic [PTRW-1:0] lowest_row(input logic [ROWS-1:0] m);
    lowest_row = '0;
    for (int r = ROWS - 1; r >= 0; r--)
      if (m[r]) lowest_row = PTRW'(r);
  endfunction

  function automatic logic any_above(input logic [ROWS-1:0] m,
                                     input logic [PTRW-1:0] s);
    any_above = 1'b0;
    for (int r = 0; r < ROWS; r++)
      if (m[r] && (PTRW'(r) > s)) any_above = 1'b1;
  endfunction

  always_comb begin
    ahead = '0;
    for (int r = 0; r < ROWS; r++)
      ahead[r] = SC_MARCH_rowAlive_In[r] && (PTRW'(r) >= ptr_q);
  end

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    ptr_d      = ptr_q;
    row_step_d = '0;
    dir_d      = dir_q;
    sweep_d    = 1'b0;
    pass_st    = state_q;
    sel        = '0;
    step_inc   = step_q + SW'(1);

    if (clear) begin
      state_d = ST_RIGHT;
      step_d  = '0;
      ptr_d   = '0;
      dir_d   = DIR_RIGHT;
    end else if (tick && (|SC_MARCH_rowAlive_In)) begin
      if (|ahead) begin
        sel = lowest_row(ahead);
      end else begin
        // Pass complete: advance the sweep and serve the new pass now.
        if ((state_q == ST_DOWN_R) || (state_q == ST_DOWN_L) ||
            (step_inc == SW'(STEPS))) begin
          pass_st = next_sweep(state_q);
          step_d  = '0;
        end else begin
          step_d  = step_inc;
        end
        sel = lowest_row(SC_MARCH_rowAlive_In);
      end
      state_d    = pass_st;
      row_step_d = ROWS'(1) << sel;
      ptr_d      = sel + PTRW'(1);
      dir_d      = state_dir(pass_st);
      // Flag the sweep end on the strobe that leaves no alive row above it.
      sweep_d    = ((pass_st == ST_DOWN_R) || (pass_st == ST_DOWN_L)) &&
                   !any_above(SC_MARCH_rowAlive_In, sel);
    end
  end

  always_ff @(posedge SC_MARCH_CLOCK_50 or negedge SC_MARCH_RESET_InLow) begin
    if (!SC_MARCH_RESET_InLow) begin
      state_q    <= ST_RIGHT;
      step_q     <= '0;
      ptr_q      <= '0;
      row_step_q <= '0;
      dir_q      <= DIR_RIGHT;
      sweep_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      ptr_q      <= ptr_d;
      row_step_q <= row_step_d;
      dir_q      <= dir_d;
      sweep_q    <= sweep_d;
    end
  end

  assign SC_MARCH_rowStep_Out   = row_step_q;
  assign SC_MARCH_dir_Out       = dir_q;
  assign SC_MARCH_sweepDone_Out = sweep_q;

endmodule

// File: tb/tb_sc_march_scheduler.sv
// tb_sc_march_scheduler: directed scenarios with literal expectations plus a
// randomized run, all cross-checked every cycle against an integer model of
// the march rules (countdown, row pass, sweep phase, period).
module tb_sc_march_scheduler;

  localparam int ROWS  = 3;
  localparam int PW    = 20;
  localparam int STEPS = 2;
  localparam int BASE  = 4;
  localparam int SPD   = 1;
  localparam int MINP  = 2;

  logic            clk = 1'b0;
  logic            rst_n, run_n, clr_n, kill_n;
  logic [ROWS-1:0] alive;
  logic [ROWS-1:0] row_step;
  logic [1:0]      dir;
  logic            sweep;
  logic [PW-1:0]   period;

  always #5 clk = ~clk;

  sc_march_scheduler #(
    .ROWS        (ROWS),
    .PW          (PW),
    .BASE_PERIOD (PW'(BASE)),
    .SPEEDUP     (PW'(SPD)),
    .MIN_PERIOD  (PW'(MINP)),
    .STEPS       (STEPS)
  ) dut (
    .SC_MARCH_CLOCK_50      (clk),
    .SC_MARCH_RESET_InLow   (rst_n),
    .SC_MARCH_run_InLow     (run_n),
    .SC_MARCH_clear_InLow   (clr_n),
    .SC_MARCH_kill_InLow    (kill_n),
    .SC_MARCH_rowAlive_In   (alive),
    .SC_MARCH_rowStep_Out   (row_step),
    .SC_MARCH_dir_Out       (dir),
    .SC_MARCH_sweepDone_Out (sweep),
    .SC_MARCH_period_Out    (period)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int need[4] = '{STEPS, 1, STEPS, 1};   // passes per sweep phase
  int dirs[4] = '{1, 0, 2, 0};           // dir code per sweep phase
  int m_cnt, m_period, m_phase, m_pass, m_ptr;
  int e_step, e_dir, e_sweep;

  task automatic model_reset();
    m_cnt = BASE - 1; m_period = BASE; m_phase = 0; m_pass = 0; m_ptr = 0;
    e_step = 0; e_dir = 1; e_sweep = 0;
  endtask

  task automatic model_step();
    int sel;
    bit tick, last;
    e_step = 0; e_sweep = 0;
    if (!clr_n) begin
      model_reset();
    end else begin
      tick = (run_n == 1'b0) && (m_cnt == 0);
      if (run_n == 1'b0) m_cnt = (m_cnt == 0) ? m_period - 1 : m_cnt - 1;
      if (kill_n == 1'b0) m_period = (m_period - SPD > MINP) ? m_period - SPD : MINP;
      if (tick && alive != 0) begin
        sel = -1;
        for (int r = m_ptr; r < ROWS; r++) if (alive[r] && sel < 0) sel = r;
        if (sel < 0) begin
          m_pass++;
          if (m_pass >= need[m_phase]) begin
            m_phase = (m_phase + 1) % 4;
            m_pass  = 0;
          end
          for (int r = 0; r < ROWS; r++) if (alive[r] && sel < 0) sel = r;
        end
        m_ptr  = sel + 1;
        e_step = 1 << sel;
        e_dir  = dirs[m_phase];
        last   = 1;
        for (int r = sel + 1; r < ROWS; r++) if (alive[r]) last = 0;
        e_sweep = (m_phase % 2 == 1) && last;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_rowStep", row_step, e_step);
      chk("cyc_dir", dir, e_dir);
      chk("cyc_sweepDone", sweep, e_sweep);
      chk("cyc_period", period, m_period);
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_strobe(input int budget, output logic [ROWS-1:0] rs,
                             output logic [1:0] d, output logic sw, output int waited);
    rs = '0; d = '0; sw = 1'b0; waited = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      waited = i + 1;
      if (row_step != 0) begin
        rs = row_step; d = dir; sw = sweep;
        return;
      end
    end
    n_tests++;
    n_fail++;
    $display("FAIL strobe_timeout: got no strobe within %0d cycles at %0t", budget, $time);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_rowStep", row_step, 0);
    chk("rst_dir", dir, 1);
    chk("rst_sweepDone", sweep, 0);
    chk("rst_period", period, BASE);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic kill_pulse();
    @(negedge clk); kill_n = 1'b0;
    @(negedge clk); kill_n = 1'b1;
  endtask

  int t1_rows[10] = '{1, 2, 4, 1, 2, 4, 1, 2, 4, 1};
  int t1_dirs[10] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 2};
  int t1_swp[10]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
  int t2_rows[5]  = '{1, 4, 1, 4, 1};

  logic [ROWS-1:0] rs;
  logic [1:0]      d;
  logic            sw;
  int              w, cnt;

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish by 200000");
    $fatal(1, "global timeout");
  end

  initial begin
    rst_n = 1'b0; run_n = 1'b0; clr_n = 1'b1; kill_n = 1'b1; alive = 3'b111;
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1;

    // 1: full sweep with all rows alive
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      wait_strobe(20, rs, d, sw, w);
      chk("t1_row", rs, t1_rows[i]);
      chk("t1_dir", d, t1_dirs[i]);
      chk("t1_sweepDone", sw, t1_swp[i]);
      chk("t1_gap", w, 4);
    end

    // 2: middle row dead, then top row dies mid-pass
    alive = 3'b101;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      wait_strobe(20, rs, d, sw, w);
      chk("t2_row", rs, t2_rows[i]);
      chk("t2_gap", w, 4);
    end
    alive = 3'b001;
    wait_strobe(20, rs, d, sw, w);
    chk("t2_drop_row", rs, 1);
    chk("t2_drop_gap", w, 4);

    // 3: kills, including one on the tick cycle
    alive = 3'b111;
    apply_reset();
    repeat (3) @(negedge clk);
    kill_n = 1'b0;
    wait_strobe(20, rs, d, sw, w);
    kill_n = 1'b1;
    chk("t3_tick_kill_gap", w, 1);
    chk("t3_period_a", period, 3);
    wait_strobe(20, rs, d, sw, w);
    chk("t3_old_period_gap", w, 4);
    wait_strobe(20, rs, d, sw, w);
    chk("t3_new_period_gap", w, 3);
    kill_pulse();
    chk("t3_period_b", period, 2);
    kill_pulse();
    chk("t3_period_floor", period, 2);

    // 4: no live rows
    alive = 3'b000;
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (row_step != 0) cnt++;
    end
    chk("t4_no_strobes", cnt, 0);
    alive = 3'b010;
    wait_strobe(10, rs, d, sw, w);
    chk("t4_revive_row", rs, 2);

    // 5: async reset mid LEFT pass, then clear after kills
    alive = 3'b111;
    apply_reset();
    kill_pulse();
    kill_pulse();
    for (int i = 0; i < 11; i++) wait_strobe(20, rs, d, sw, w);
    chk("t5_in_left", d, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_rowStep", row_step, 0);
    chk("t5_rst_dir", dir, 1);
    chk("t5_rst_period", period, BASE);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_strobe(20, rs, d, sw, w);
    chk("t5_restart_row", rs, 1);
    chk("t5_restart_dir", d, 1);
    chk("t5_restart_gap", w, 4);
    kill_pulse();
    kill_pulse();
    for (int i = 0; i < 3; i++) wait_strobe(20, rs, d, sw, w);
    clr_n = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;
    chk("t5_clr_period", period, BASE);
    chk("t5_clr_rowStep", row_step, 0);
    chk("t5_clr_dir", dir, 1);
    wait_strobe(20, rs, d, sw, w);
    chk("t5_clr_row", rs, 1);
    chk("t5_clr_gap", w, 4);

    // 6: freeze mid-pass for 10 cycles
    @(negedge clk);
    run_n = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (row_step != 0) cnt++;
    end
    run_n = 1'b0;
    chk("t6_frozen", cnt, 0);
    wait_strobe(20, rs, d, sw, w);
    chk("t6_resume_row", rs, 2);
    chk("t6_resume_gap", w, 3);

    // randomized traffic, model-checked every cycle
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 15) == 0) alive = 3'($urandom_range(0, 7));
      kill_n = ($urandom_range(0, 19) != 0);
      run_n  = ($urandom_range(0, 9) == 0);
      clr_n  = ($urandom_range(0, 299) != 0);
    end
    @(negedge clk);
    kill_n = 1'b1; run_n = 1'b0; clr_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
